// File: rtl/uart_pkg.sv
// Shared UART constants: bit timing, frame width and the FSM state encoding
// common to the transmitter and receiver.
package uart_pkg;

`ifdef SIM
    localparam logic [12:0] T_DIV      = 13'd7;
    localparam logic [12:0] T_DIV_HALF = 13'd3;
`else
    localparam logic [12:0] T_DIV      = 13'd434;
    localparam logic [12:0] T_DIV_HALF = 13'd217;
`endif

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector on the synchronized value.
module uart_rx_sync (
    input  logic clk,
    input  logic n_rst,
    input  logic rxd,
    output logic rxd_s,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Resetting to the idle level keeps a spurious edge from appearing after reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rxd;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rxd_s = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detection, mid-bit sampling, byte assembly
// and one-cycle valid / framing-error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter logic [12:0] T_DIV      = uart_pkg::T_DIV,
    parameter logic [12:0] T_DIV_HALF = uart_pkg::T_DIV_HALF
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       rx_busy
);

    logic rxd_s;
    logic fall;

    uart_rx_sync u_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .rxd   (rxd),
        .rxd_s (rxd_s),
        .fall  (fall)
    );

    state_t      state_q, state_d;
    logic [12:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            baud_q  <= 13'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 13'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            // Only an edge arms the receiver, so a held-low break never retriggers.
            IDLE: begin
                baud_d = 13'd0;
                if (fall) state_d = START;
            end
            START: begin
                if (baud_q == T_DIV_HALF - 13'd1) begin
                    baud_d  = 13'd0;
                    bit_d   = 3'd0;
                    state_d = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_q == T_DIV - 13'd1) begin
                    baud_d  = 13'd0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
                    else                            bit_d   = bit_q + 3'd1;
                end
            end
            // Returning to IDLE at the stop sample leaves half a bit to catch a back-to-back start edge.
            STOP: begin
                if (baud_q == T_DIV - 13'd1) begin
                    baud_d  = 13'd0;
                    state_d = IDLE;
                    if (rxd_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_err   = err_q;
    assign rx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames are driven bit by bit and every
// expected strobe is queued before the frame and checked when it appears.
module tb_uart_rx;

    localparam int T_DIV = 7;

    logic       clk;
    logic       n_rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       rx_busy;

    uart_rx #(
        .T_DIV      (13'd7),
        .T_DIV_HALF (13'd3)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .rx_busy  (rx_busy)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // scoreboard entries: {is_err, rx_data}
    logic [8:0] exp_q[$];
    int         valid_cycs[$];
    int         start_cyc;

    task automatic check(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Each bit level is held for T_DIV cycles; called and returns at a posedge.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            #1 rxd = f[i];
            if (i == 0) start_cyc = cyc + 1;
            repeat (T_DIV) @(posedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  rx_data,  0);
        check({tag, "_valid"}, rx_valid, 0);
        check({tag, "_err"},   rx_err,   0);
        check({tag, "_busy"},  rx_busy,  0);
    endtask

    // monitor: pop and compare on every strobe
    always @(negedge clk) begin
        if (n_rst && (rx_valid || rx_err)) begin
            check("strobe_excl", int'(rx_valid & rx_err), 0);
            if (rx_valid) valid_cycs.push_back(cyc);
            if (exp_q.size() > 0) begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("strobe", int'({rx_err, rx_data}), int'(e));
            end else begin
                check("unexpected_strobe", int'({rx_err, rx_data}), 'h1FF);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int base;
        int lat;
        logic [9:0] f;

        n_rst = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (3) @(posedge clk);

        // loopback bytes with latency measurement on the first
        exp_q.push_back({1'b0, 8'h37});
        send_frame(8'h37, 1'b1);
        repeat (5) @(posedge clk);
        check("valid_count_37", valid_cycs.size(), 1);
        if (valid_cycs.size() > 0) begin
            lat = valid_cycs[valid_cycs.size() - 1] - start_cyc;
            check("latency", lat, 68);
        end
        exp_q.push_back({1'b0, 8'h20});
        send_frame(8'h20, 1'b1);
        repeat (5) @(posedge clk);

        // framing error, then a held-low break must not retrigger
        exp_q.push_back({1'b1, 8'h20});
        send_frame(8'hA5, 1'b0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_busy) cnt++;
        end
        check("break_busy", cnt, 0);
        check("data_held", rx_data, 8'h20);
        @(posedge clk);
        #1 rxd = 1'b1;
        repeat (10) @(posedge clk);

        // two-cycle glitch
        #1 rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1 rxd = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_busy) cnt++;
        end
        check("glitch_seen", int'(cnt > 0), 1);
        check("glitch_busy_max", int'(cnt <= 6), 1);
        @(posedge clk);
        repeat (3) @(posedge clk);

        // back-to-back frames
        base = valid_cycs.size();
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b0, 8'h55});
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        repeat (5) @(posedge clk);
        check("b2b_count", valid_cycs.size() - base, 3);
        if (valid_cycs.size() - base >= 3) begin
            check("b2b_gap1", valid_cycs[base + 1] - valid_cycs[base], 10 * T_DIV);
            check("b2b_gap2", valid_cycs[base + 2] - valid_cycs[base + 1], 10 * T_DIV);
        end
        repeat (5) @(posedge clk);

        // reset during data bit 4 of 8'h3C
        f = {1'b1, 8'h3C, 1'b0};
        for (int i = 0; i < 5; i++) begin
            #1 rxd = f[i];
            repeat (T_DIV) @(posedge clk);
        end
        #1 rxd = f[5];
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b0;
        rxd = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (5) @(posedge clk);

        exp_q.push_back({1'b0, 8'h81});
        send_frame(8'h81, 1'b1);
        repeat (10) @(posedge clk);
        check("final_data", rx_data, 8'h81);
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
